uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter: a bus responder on the core's data-memory interface (`wen`/`wa`/`wd`/`funct3` write side, `ra`/`rd` read side), in parallel with the main memory. Software writes bytes into a transmit FIFO. An 8N1 serializer then shifts them out on a single `tx` pin. Status and baud divisor are readable and writable through the same address window.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: base of the 16-byte register window.
- `CLKS_PER_BIT`, default 1250: reset value of the baud divisor (12 MHz / 9600).
- `FIFO_DEPTH`, default 8: transmit FIFO entries. Must be a power of two, ≥2.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `mem_wen`, input, 1: write strobe from the core.
- `mem_wa`, input, 32: write address.
- `mem_wd`, input, 32: write data.
- `mem_funct3`, input, 3: access width. 000 = byte, 001 = half, 010 = word; other values are treated as word.
- `mem_ra`, input, 32: read address.
- `mem_rd`, output, 32: registered read data. 0 when the read address is outside the window.
- `rd_hit`, output, 1: registered. Asserted when the returned `mem_rd` came from this block; used by the top level to mux against memory.
- `tx`, output, 1: serial line, idles high.

## Operation
- Register map, as offsets from `BASE_ADDR`. Only bits [3:2] are decoded; the window is 16 bytes.
  - 0x0 TXDATA (W): pushes `mem_wd[7:0]` for any width. Reads return 0.
  - 0x4 STATUS (R/W1C):
    - bit0 busy: FSM not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow: sticky. Cleared by writing 1 to bit3.
    - bits[11:8]: FIFO count.
  - 0x8 BAUD_DIV (RW, 16 bits). A byte write updates [7:0]; a half or word write updates [15:0]. Reads are zero-extended.
  - 0xC: reserved. Reads return 0; writes are ignored.
- Push to a full FIFO: data is dropped and overflow is set. Fullness is evaluated on the pre-pop count, so a push coinciding with a pop while full is still dropped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The byte is popped into the shift register and the divisor is latched on the same edge.
  - START → DATA after one bit period.
  - DATA holds for 8 bit periods, sending LSB first, then goes to STOP.
  - STOP → START if the FIFO is non-empty (back-to-back frames, no idle gap). Otherwise STOP → IDLE.
- Bit period = latched divisor clocks. A divisor of 0 is treated as 1. BAUD_DIV writes take effect at the next frame start; they never apply mid-frame.
- Bit counter: 3 bits, wraps 7→0 on the DATA→STOP transition. Baud counter: 16 bits, counts down from divisor−1.

## Timing
- Reset values:
  - `tx` = 1, `mem_rd` = 0, `rd_hit` = 0.
  - FIFO empty, overflow 0, BAUD_DIV = `CLKS_PER_BIT`, FSM in IDLE.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous) and the FIFO contents are discarded.
- Write to TXDATA with the FIFO empty and the FSM idle, captured at edge E0:
  - `tx` goes low after edge E0+1.
  - Each frame lasts exactly 10 × divisor cycles.
- Read latency is 1 cycle: `mem_ra` sampled at edge E drives `mem_rd`/`rd_hit` after E.
- STATUS read in the same cycle as a push returns the pre-push values.
- A simultaneous W1C and overflow-setting push leaves overflow set.
- Writes and reads are independent and may occur in the same cycle.

## Configuration
- `UART_TX_FIFO_EN` defined: FIFO of `FIFO_DEPTH` entries; count field as described.
- Not defined:
  - The FIFO is replaced by a single holding register; full = holding register occupied, count ∈ {0,1}.
  - `FIFO_DEPTH` is ignored. All other behaviour is identical.

## Structure
- Package `uart_tx_pkg`:
  - register offset constants (TXDATA, STATUS, BAUD_DIV);
  - STATUS bit-position constants;
  - FSM state enum `tx_state_t`.
- Sub-module `uart_tx_fifo`:
  - synchronous FIFO with push/pop/full/empty/count;
  - compiled as the depth-1 holding register when `UART_TX_FIFO_EN` is absent.
- The top level adds this block beside the memory and muxes `mem_rd` on `rd_hit`.

## Test plan
- Reset, then word write 0x55 to BASE+0x0 with BAUD_DIV = 4 → `tx` low after 1 cycle, then 4-cycle bits 1,0,1,0,1,0,1,0, stop high, frame 40 cycles; STATUS busy=1 during the frame, 0 after.
- Write 0xA3 and 0x0F back-to-back with BAUD_DIV = 2 → two contiguous 20-cycle frames with no idle between stop and the second start.
- With a frame in progress and the FIFO filled, push 2 more bytes → STATUS reads full=1, overflow=1, count=8; write 0x8 to STATUS → overflow=0; dropped bytes are never transmitted.
- Byte write 0x10 to BASE+0x8 (old value 0x1234) → reads 0x0000_1210; a mid-frame change does not alter the current frame's bit length.
- Read BASE+0x4 and then 0x0000_0100 → `rd_hit` = 1 then 0, `mem_rd` = 0 on the miss.
- Assert `rst_n` low during the DATA state → `tx` = 1 immediately; after release STATUS reads empty=1, count=0, BAUD_DIV = 1250.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Optional FIFO selected by UART_TX_FIFO_EN (see uart_tx_fifo).
package uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue: FIFO_DEPTH entries with UART_TX_FIFO_EN,
// otherwise a single holding register.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

`ifdef UART_TX_FIFO_EN
  localparam int D  = DEPTH;
  localparam int AW = $clog2(DEPTH);
`else
  // without the FIFO the depth collapses to one entry
  localparam int D  = DEPTH / DEPTH;
`endif

  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt == CNT_W'(D);
  assign empty   = cnt == '0;
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(do_push)
                 - CNT_W'(do_pop);
    end
  end

`ifdef UART_TX_FIFO_EN
  logic [7:0]    mem [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  assign dout = mem[rp];
`else
  logic [7:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (do_push) begin
      hold <= din;
    end
  end

  assign dout = hold;
`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with status and baud registers.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry transmit queue.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 1250,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wen,
  input  logic [31:0] mem_wa,
  input  logic [31:0] mem_wd,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_ra,
  output logic [31:0] mem_rd,
  output logic        rd_hit,
  output logic        tx
);

  logic             wr_hit;
  logic             push_req;
  logic             st_wr;
  logic             baud_wr;
  logic             rd_in;
  logic [31:0]      rd_next;
  logic [31:0]      status;
  logic [15:0]      baud;
  logic             ovf;
  logic [7:0]       dout;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             frame_go;
  logic             bit_done;
  logic [15:0]      div_new;
  tx_state_t        state;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [15:0]      baud_cnt;
  logic [15:0]      div_q;
  logic             unused_bits;

  assign wr_hit   = mem_wen
                 && mem_wa[31:4] == BASE_ADDR[31:4];
  assign push_req = wr_hit && mem_wa[3:2] == OFF_TXDATA;
  assign st_wr    = wr_hit && mem_wa[3:2] == OFF_STATUS;
  assign baud_wr  = wr_hit && mem_wa[3:2] == OFF_BAUD;
  assign rd_in    = mem_ra[31:4] == BASE_ADDR[31:4];

  assign unused_bits = ^{mem_wa[1:0], mem_ra[1:0],
                         mem_wd[31:16],
                         count[CNT_W-1:4]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (mem_wd[7:0]),
    .pop   (frame_go),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // a rejected push wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push_req && full) begin
      ovf <= 1'b1;
    end else if (st_wr && mem_wd[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud <= 16'(CLKS_PER_BIT);
    end else if (baud_wr) begin
      if (mem_funct3 == 3'b000) begin
        baud[7:0] <= mem_wd[7:0];
      end else begin
        baud <= mem_wd[15:0];
      end
    end
  end

  always_comb begin
    status            = '0;
    status[ST_BUSY]   = state != S_IDLE;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_OVF]    = ovf;
    status[ST_CNT+:4] = count[3:0];
  end

  always_comb begin
    rd_next = '0;
    if (rd_in) begin
      case (mem_ra[3:2])
        OFF_STATUS: rd_next = status;
        OFF_BAUD:   rd_next = {16'h0, baud};
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd <= '0;
      rd_hit <= 1'b0;
    end else begin
      mem_rd <= rd_next;
      rd_hit <= rd_in;
    end
  end

  assign bit_done = baud_cnt == 16'd0;
  assign div_new  = eff_div(baud);
  assign frame_go = !empty
                 && (state == S_IDLE
                  || (state == S_STOP && bit_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      div_q    <= 16'd1;
    end else if (frame_go) begin
      state    <= S_START;
      tx       <= 1'b0;
      shreg    <= dout;
      div_q    <= div_new;
      baud_cnt <= div_new - 16'd1;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            tx       <= shreg[0];
            bit_cnt  <= '0;
            baud_cnt <= div_q - 16'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= div_q - 16'd1;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= shreg[1];
              shreg <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            state <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: directed and random register traffic
// against a frame-level line monitor and register reference model.
module tb_uart_tx_mmio;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_BD = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic        mem_wen;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_ra;
  logic [31:0] mem_rd;
  logic        rd_hit;
  logic        tx;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (1250),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_wen    (mem_wen),
    .mem_wa     (mem_wa),
    .mem_wd     (mem_wd),
    .mem_funct3 (mem_funct3),
    .mem_ra     (mem_ra),
    .mem_rd     (mem_rd),
    .rd_hit     (rd_hit),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0]  mdl_q[$];
  logic        mdl_ovf = 1'b0;
  logic [15:0] mdl_div = 16'd1250;
  logic [15:0] div_snap;
  bit          mon_en = 1'b1;
  int          push_cyc;

  // line monitor: decodes 8N1 frames at the divisor in force
  bit         m_active = 1'b0;
  int         m_cnt;
  int         m_div;
  int         m_k;
  logic [7:0] m_byte;
  logic [7:0] m_exp;
  int         start_q[$];
  int         frames = 0;

  always @(posedge clk) begin
    div_snap = mdl_div;
    #2;
    if (!mon_en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_div    = (div_snap == 0) ? 1 : int'(div_snap);
        m_byte   = '0;
        start_q.push_back(cyc);
        check("start_has_data",
              32'(mdl_q.size() != 0), 32'd1);
        m_exp = (mdl_q.size() != 0)
              ? mdl_q.pop_front() : 8'h00;
      end else if (m_active) begin
        m_cnt++;
      end
      if (m_active) begin
        if (m_cnt % m_div == m_div / 2) begin
          m_k = m_cnt / m_div;
          if (m_k == 0) check("start_bit", 32'(tx), 32'd0);
          else if (m_k <= 8) m_byte[m_k-1] = tx;
          else check("stop_bit", 32'(tx), 32'd1);
        end
        if (m_cnt == 10 * m_div - 1) begin
          check("frame_byte", 32'(m_byte), 32'(m_exp));
          frames++;
          m_active = 1'b0;
        end
      end
    end
  end

  // one bus cycle: optional write and optional checked read
  task automatic xfer(input bit w,
                      input logic [31:0] wa,
                      input logic [31:0] wd,
                      input logic [2:0] f3,
                      input bit r,
                      input logic [31:0] ra,
                      input string tag,
                      input int busy_exp);
    logic [31:0] rdat;
    logic [31:0] e;
    logic        hit;
    logic        e_hit;
    int          sz;
    mem_wen    = w;
    mem_wa     = wa;
    mem_wd     = wd;
    mem_funct3 = f3;
    mem_ra     = r ? ra : 32'h0;
    @(posedge clk);
    #1;
    rdat     = mem_rd;
    hit      = rd_hit;
    push_cyc = cyc;
    sz       = mdl_q.size();
    e_hit    = ra[31:4] == BASE[31:4];
    e        = '0;
    if (e_hit && ra[3:2] == 2'd1) begin
      e[1]    = sz == DEPTH;
      e[2]    = sz == 0;
      e[3]    = mdl_ovf;
      e[11:8] = 4'(sz);
      if (busy_exp < 0) rdat[0] = 1'b0;
      else e[0] = busy_exp[0];
    end else if (e_hit && ra[3:2] == 2'd2) begin
      e = {16'h0, mdl_div};
    end
    if (r) begin
      check({tag, "_hit"}, 32'(hit), 32'(e_hit));
      check({tag, "_rd"}, rdat, e);
    end
    if (w && wa[31:4] == BASE[31:4]) begin
      case (wa[3:2])
        2'd0: begin
          if (sz < DEPTH) mdl_q.push_back(wd[7:0]);
          else mdl_ovf = 1'b1;
        end
        2'd1: if (wd[3]) mdl_ovf = 1'b0;
        2'd2: begin
          if (f3 == 3'b000) mdl_div[7:0] = wd[7:0];
          else mdl_div = wd[15:0];
        end
        default: ;
      endcase
    end
    mem_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [2:0] f3);
    xfer(1'b1, a, d, f3, 1'b0, 32'h0, "", -1);
  endtask

  task automatic rd(input logic [31:0] a,
                    input string tag,
                    input int busy_exp);
    xfer(1'b0, 32'h0, 32'h0, 3'd2, 1'b1, a, tag, busy_exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget);
    int s0 = start_q.size();
    for (int i = 0; i < budget; i++) begin
      if (start_q.size() > s0) break;
      @(negedge clk);
    end
    check("start_seen", 32'(start_q.size() > s0), 32'd1);
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mdl_q.size() == 0 && !m_active) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drained", 32'(done), 32'd1);
    idle(3);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    logic [31:0] v;
    rst_n      = 1'b0;
    mem_wen    = 1'b0;
    mem_wa     = '0;
    mem_wd     = '0;
    mem_funct3 = 3'd2;
    mem_ra     = '0;
    idle(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd", mem_rd, 32'd0);
    check("rst_hit", 32'(rd_hit), 32'd0);
    rst_n = 1'b1;
    idle(2);
    rd(A_ST, "rst_status", 0);
    rd(A_BD, "rst_baud", -1);

    // single frame, divisor 4
    wr(A_BD, 32'd4, 3'd2);
    xfer(1'b1, A_TX, 32'hFFFF_FF55, 3'd2,
         1'b1, A_ST, "prepush_st", 0);
    wait_start(10);
    check("start_latency", start_q[start_q.size()-1] - push_cyc, 1);
    idle(10);
    rd(A_ST, "busy_mid", 1);
    drain(100);
    rd(A_ST, "busy_after", 0);

    // back-to-back frames, divisor 2
    wr(A_BD, 32'd2, 3'd2);
    wr(A_TX, 32'hA3, 3'd0);
    idle(1);
    wr(A_TX, 32'h0F, 3'd1);
    drain(200);
    n = start_q.size();
    check("b2b_gap", start_q[n-1] - start_q[n-2], 20);

    // overflow and clear
    wr(A_BD, 32'd8, 3'd2);
    wr(A_TX, 32'h11, 3'd2);
    wait_start(10);
    for (int i = 0; i < DEPTH + 2; i++)
      wr(A_TX, 32'($urandom_range(0, 255)), 3'd2);
    xfer(1'b0, 32'h0, 32'h0, 3'd2, 1'b1, A_ST, "ovf_st", 1);
    check("ovf_model", 32'(mdl_ovf), 32'd1);
    wr(A_ST, 32'h8, 3'd2);
    rd(A_ST, "ovf_clr", 1);
    drain(3000);

    // divisor write widths and mid-frame change
    wr(A_BD, 32'h1234, 3'd2);
    wr(A_BD, 32'hFFFF_FF10, 3'd0);
    rd(A_BD, "baud_byte", -1);
    check("baud_byte_val", {16'h0, mdl_div}, 32'h1210);
    wr(A_BD, 32'hABCD_0005, 3'd1);
    rd(A_BD, "baud_half", -1);
    wr(A_BD, 32'h0009_0003, 3'd7);
    rd(A_BD, "baud_f3_7", -1);
    wr(A_TX, 32'h5A, 3'd2);
    wait_start(10);
    wr(A_BD, 32'd6, 3'd2);
    wr(A_TX, 32'hC3, 3'd2);
    drain(300);
    n = start_q.size();
    check("midframe_len", start_q[n-1] - start_q[n-2], 30);

    // window decode
    rd(A_TX, "txdata_rd", -1);
    rd(A_RS, "resv_rd", -1);
    wr(A_RS, 32'hFFFF_FFFF, 3'd2);
    rd(A_ST, "resv_wr_st", 0);
    rd(32'h0000_0100, "miss_rd", -1);
    rd(BASE + 32'h14, "near_miss", -1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      v  = $urandom;
      case (op)
        0, 1, 2, 3:
          xfer(1'b1, A_TX, v, 3'($urandom_range(0, 7)),
               v[31], A_ST, "rnd_push_st", -1);
        4: rd(A_ST, "rnd_st", -1);
        5: rd(A_BD, "rnd_bd", -1);
        6: wr(A_BD, 32'($urandom_range(0, 4)), 3'd2);
        7: wr(A_ST, v, 3'd2);
        8: idle($urandom_range(1, 20));
        default:
          wr(A_BD, 32'($urandom_range(0, 4)), 3'd0);
      endcase
    end
    drain(6000);
    rd(A_ST, "rnd_end_st", 0);

    // asynchronous reset during the data bits
    wr(A_BD, 32'd8, 3'd2);
    wr(A_TX, 32'h00, 3'd2);
    wait_start(10);
    idle(20);
    check("pre_rst_tx", 32'(tx), 32'd0);
    wr(A_TX, 32'h77, 3'd2);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    check("rst_rd_async", mem_rd, 32'd0);
    check("rst_hit_async", 32'(rd_hit), 32'd0);
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_div = 16'd1250;
    idle(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    rd(A_ST, "post_rst_st", 0);
    rd(A_BD, "post_rst_bd", -1);
    idle(30);
    check("post_rst_idle", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
